// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator: scans WIDTH-bit operands CHUNK bits
// per cycle, MSB chunk first, with optional signed order and early exit.
module seq_magnitude_comparator #(
  parameter  int WIDTH      = 16,
  parameter  int CHUNK      = 4,
  parameter  int EARLY_EXIT = 1,
  localparam int NCHUNK     = WIDTH / CHUNK,
  localparam int CW         = $clog2(NCHUNK + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             is_signed,
  output logic             busy,
  output logic             done,
  output logic             A_greater,
  output logic             A_equal,
  output logic             A_less,
  output logic [CW-1:0]    chunks_used
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COMPARE = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [CW-1:0]    k;
  logic             dec;
  logic             dgt;

  logic [CHUNK-1:0] top_a;
  logic [CHUNK-1:0] top_b;
  logic             diff;
  logic             cgt;
  logic             nd_gt;
  logic             nd_lt;
  logic             last;
  logic             finish;
  logic [WIDTH-1:0] sign_mask;

  // Operands shift left each cycle so the current chunk is always on top.
  assign top_a  = a_q[WIDTH-1 -: CHUNK];
  assign top_b  = b_q[WIDTH-1 -: CHUNK];
  assign diff   = top_a != top_b;
  assign cgt    = top_a > top_b;
  assign nd_gt  = dec ? dgt  : (diff & cgt);
  assign nd_lt  = dec ? !dgt : (diff & !cgt);
  assign last   = k == CW'(NCHUNK - 1);
  assign finish = last | ((EARLY_EXIT != 0) & diff);

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  assign sign_mask = WIDTH'(is_signed) << (WIDTH - 1);

  assign busy = state == COMPARE;
  assign done = state == DONE;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      k           <= '0;
      dec         <= 1'b0;
      dgt         <= 1'b0;
      A_greater   <= 1'b0;
      A_equal     <= 1'b0;
      A_less      <= 1'b0;
      chunks_used <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            a_q   <= A ^ sign_mask;
            b_q   <= B ^ sign_mask;
            k     <= '0;
            dec   <= 1'b0;
            dgt   <= 1'b0;
            state <= COMPARE;
          end else begin
            state <= IDLE;
          end
        end
        COMPARE: begin
          a_q <= a_q << CHUNK;
          b_q <= b_q << CHUNK;
          k   <= k + 1'b1;
          if (!dec && diff) begin
            dec <= 1'b1;
            dgt <= cgt;
          end
          if (finish) begin
            state       <= DONE;
            A_greater   <= nd_gt;
            A_equal     <= !nd_gt && !nd_lt;
            A_less      <= nd_lt;
            chunks_used <= k + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
